// File: rtl/pipeline_stall_controller_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller_pkg
// Shared constants for the pipeline stall controller:
//   - stall bit polarity (STALL_ENABLE / STALL_DISABLE) and reset polarity
//   - stage indices into the 6-bit stall vector (PC, IF, ID, EX, MEM, WB)
//   - EX multi-cycle sequencer state encodings
//   - stall_through(): builds a vector stalling stage 0 up to a given stage
// ---------------------------------------------------------------------------
package pipeline_stall_controller_pkg;

    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = 1'b0;
    localparam logic RESET_ENABLE  = 1'b1;

    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;
    localparam int NUM_STAGES = 6;

    localparam logic SEQ_IDLE = 1'b0;
    localparam logic SEQ_BUSY = 1'b1;

    localparam logic [NUM_STAGES-1:0] STALL_NONE = '0;

    // A request from stage k freezes stage k and everything upstream of it;
    // the first unstalled stage downstream receives a bubble.
    function automatic logic [NUM_STAGES-1:0] stall_through(input int deepest);
        logic [NUM_STAGES-1:0] v;
        for (int i = 0; i < NUM_STAGES; i++) begin
            v[i] = (i <= deepest) ? STALL_ENABLE : STALL_DISABLE;
        end
        return v;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_ex_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// ex_multicycle_sequencer
// Holds the EX stage for multi-cycle operations (MADD/MSUB/DIV style).
// An N-cycle op holds EX for N-1 cycles; done is raised in the final cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no op in flight; a start with N>=2 loads the counter
// BUSY  | op in flight; counter = remaining EX cycles including the done one
//
// Ports:
//   clock, reset         rising-edge clock, async active-high reset
//   flush                aborts the op, forces IDLE
//   mem_stall_request    MEM is stalled; counter and done cycle are frozen
//   start, cycles        start pulse and total op length N
//   ex_hold              request to stall EX (and upstream)
//   done, busy           result valid this cycle / state is BUSY
// ---------------------------------------------------------------------------
module ex_multicycle_sequencer
    import pipeline_stall_controller_pkg::*;
#(
    parameter int COUNT_WIDTH = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   mem_stall_request,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] cycles,
    output logic                   ex_hold,
    output logic                   done,
    output logic                   busy
);

    logic                   state;
    logic                   state_next;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;

    always_comb begin
        state_next = state;
        count_next = count;
        ex_hold    = 1'b0;
        done       = 1'b0;
        if (flush) begin
            state_next = SEQ_IDLE;
            count_next = '0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (start) begin
                        if (cycles >= COUNT_WIDTH'(2)) begin
                            ex_hold    = 1'b1;
                            state_next = SEQ_BUSY;
                            count_next = cycles - COUNT_WIDTH'(1);
                        end else begin
                            done = 1'b1;
                        end
                    end
                end
                default: begin
                    if (count > COUNT_WIDTH'(1)) begin
                        ex_hold = 1'b1;
                        if (!mem_stall_request) begin
                            count_next = count - COUNT_WIDTH'(1);
                        end
                    end else begin
                        // Result stays valid until MEM can accept it.
                        done = 1'b1;
                        if (!mem_stall_request) begin
                            state_next = SEQ_IDLE;
                            count_next = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset == RESET_ENABLE) begin
            state <= SEQ_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    assign busy = (state == SEQ_BUSY);

endmodule

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
// Merges per-stage stall requests and the EX multi-cycle hold into the
// 6-bit stall vector (bit0 PC .. bit5 WB) used by the PC and stage latches.
// Outputs are combinational because the latches consume stall this cycle.
//
// Optional feature (macro STALL_COUNTER_EN): stall_cycle_count counts clock
// edges with stall[0]=1 and no flush; otherwise it is tied to zero.
//
// Ports:
//   clock, reset                      rising-edge clock, async active-high reset
//   if/id/mem_stall_request           per-stage stall requests
//   flush                             exception/redirect, overrides everything
//   ex_multicycle_start/_cycles       start pulse and op length N
//   stall                             stall vector, 1 = stall
//   ex_multicycle_done/_busy          sequencer result valid / busy
//   stall_cycle_count                 optional stall-cycle counter
// ---------------------------------------------------------------------------
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int COUNT_WIDTH       = 6,
    parameter int STALL_COUNT_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         if_stall_request,
    input  logic                         id_stall_request,
    input  logic                         mem_stall_request,
    input  logic                         flush,
    input  logic                         ex_multicycle_start,
    input  logic [COUNT_WIDTH-1:0]       ex_multicycle_cycles,
    output logic [5:0]                   stall,
    output logic                         ex_multicycle_done,
    output logic                         ex_multicycle_busy,
    output logic [STALL_COUNT_WIDTH-1:0] stall_cycle_count
);

    logic ex_hold;

    ex_multicycle_sequencer #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_ex_seq (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .mem_stall_request (mem_stall_request),
        .start             (ex_multicycle_start),
        .cycles            (ex_multicycle_cycles),
        .ex_hold           (ex_hold),
        .done              (ex_multicycle_done),
        .busy              (ex_multicycle_busy)
    );

    // Deepest requesting stage wins; WB is never stalled.
    always_comb begin
        if (flush) begin
            stall = STALL_NONE;
        end else if (mem_stall_request) begin
            stall = stall_through(STAGE_MEM);
        end else if (ex_hold) begin
            stall = stall_through(STAGE_EX);
        end else if (id_stall_request) begin
            stall = stall_through(STAGE_ID);
        end else if (if_stall_request) begin
            stall = stall_through(STAGE_IF);
        end else begin
            stall = STALL_NONE;
        end
    end

`ifdef STALL_COUNTER_EN
    logic [STALL_COUNT_WIDTH-1:0] stall_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset == RESET_ENABLE) begin
            stall_count_q <= '0;
        end else if (stall[STAGE_PC] == STALL_ENABLE && !flush) begin
            stall_count_q <= stall_count_q + STALL_COUNT_WIDTH'(1);
        end
    end

    assign stall_cycle_count = stall_count_q;
`else
    assign stall_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

    logic        clock;
    logic        reset;
    logic        if_stall_request;
    logic        id_stall_request;
    logic        mem_stall_request;
    logic        flush;
    logic        ex_multicycle_start;
    logic [5:0]  ex_multicycle_cycles;
    logic [5:0]  stall;
    logic        ex_multicycle_done;
    logic        ex_multicycle_busy;
    logic [31:0] stall_cycle_count;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic       ifr;
        logic       idr;
        logic       mem;
        logic       fl;
        logic       st;
        logic [5:0] n;
        logic [5:0] es;
        logic       ed;
        logic       eb;
    } row_t;

    // Scoreboard of expected {stall, done, busy}
    logic [7:0] exp_q[$];

    pipeline_stall_controller #(
        .COUNT_WIDTH(6),
        .STALL_COUNT_WIDTH(32)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .if_stall_request    (if_stall_request),
        .id_stall_request    (id_stall_request),
        .mem_stall_request   (mem_stall_request),
        .flush               (flush),
        .ex_multicycle_start (ex_multicycle_start),
        .ex_multicycle_cycles(ex_multicycle_cycles),
        .stall               (stall),
        .ex_multicycle_done  (ex_multicycle_done),
        .ex_multicycle_busy  (ex_multicycle_busy),
        .stall_cycle_count   (stall_cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic row_t mk(input logic ifr, input logic idr, input logic mem,
                                input logic fl, input logic st, input int n,
                                input logic [5:0] es, input logic ed, input logic eb);
        row_t r;
        r.ifr = ifr; r.idr = idr; r.mem = mem; r.fl = fl; r.st = st;
        r.n = 6'(n); r.es = es; r.ed = ed; r.eb = eb;
        return r;
    endfunction

    // Drives one cycle of stimulus at the falling edge and queues its expectation.
    task automatic apply_row(input row_t r);
        @(negedge clock);
        if_stall_request     = r.ifr;
        id_stall_request     = r.idr;
        mem_stall_request    = r.mem;
        flush                = r.fl;
        ex_multicycle_start  = r.st;
        ex_multicycle_cycles = r.n;
        exp_q.push_back({r.es, r.ed, r.eb});
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        logic [7:0] g;
        reset = 1'b1;
        if_stall_request = 0; id_stall_request = 0; mem_stall_request = 0;
        flush = 0; ex_multicycle_start = 0; ex_multicycle_cycles = '0;
        exp_q.push_back(8'b000000_0_0);
        #3;
        e = exp_q.pop_front();
        g = {stall, ex_multicycle_done, ex_multicycle_busy};
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want %b", g, e);
        end
        vectors++;
        if (stall_cycle_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d want 0", stall_cycle_count);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_requests();
        row_t tab[$];
        logic [7:0] e, g;
        tab.push_back(mk(0,0,0,0,0,0, 6'b000000,0,0));
        tab.push_back(mk(1,0,0,0,0,0, 6'b000011,0,0));
        tab.push_back(mk(0,1,0,0,0,0, 6'b000111,0,0));
        tab.push_back(mk(0,0,1,0,0,0, 6'b011111,0,0));
        tab.push_back(mk(1,1,1,0,0,0, 6'b011111,0,0));
        tab.push_back(mk(1,1,0,0,0,0, 6'b000111,0,0));
        tab.push_back(mk(0,0,1,1,0,0, 6'b000000,0,0));
        tab.push_back(mk(0,0,0,0,0,0, 6'b000000,0,0));
        foreach (tab[i]) begin
            apply_row(tab[i]);
            e = exp_q.pop_front();
            g = {stall, ex_multicycle_done, ex_multicycle_busy};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL requests row %0d: got stall=%b done=%b busy=%b want stall=%b done=%b busy=%b",
                         i, g[7:2], g[1], g[0], e[7:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_multicycle();
        row_t tab[$];
        logic [7:0] e, g;
        // N=4: three held cycles, done on the fourth
        tab.push_back(mk(0,0,0,0,1,4,  6'b001111,0,0));
        tab.push_back(mk(0,0,0,0,0,0,  6'b001111,0,1));
        tab.push_back(mk(0,0,0,0,0,0,  6'b001111,0,1));
        tab.push_back(mk(0,0,0,0,0,0,  6'b000000,1,1));
        tab.push_back(mk(0,0,0,0,0,0,  6'b000000,0,0));
        // N=3 with a second start while busy: ignored
        tab.push_back(mk(0,0,0,0,1,3,  6'b001111,0,0));
        tab.push_back(mk(0,0,0,0,1,10, 6'b001111,0,1));
        tab.push_back(mk(0,0,0,0,0,0,  6'b000000,1,1));
        tab.push_back(mk(0,0,0,0,0,0,  6'b000000,0,0));
        // N=2 with a lower-priority id request during hold
        tab.push_back(mk(0,1,0,0,1,2,  6'b001111,0,0));
        tab.push_back(mk(1,0,0,0,0,0,  6'b000011,1,1));
        tab.push_back(mk(0,0,0,0,0,0,  6'b000000,0,0));
        foreach (tab[i]) begin
            apply_row(tab[i]);
            e = exp_q.pop_front();
            g = {stall, ex_multicycle_done, ex_multicycle_busy};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL multicycle row %0d: got stall=%b done=%b busy=%b want stall=%b done=%b busy=%b",
                         i, g[7:2], g[1], g[0], e[7:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_mem_freeze();
        row_t tab[$];
        logic [7:0] e, g;
        // N=3, MEM stalls two cycles mid-op: done slips by two
        tab.push_back(mk(0,0,0,0,1,3, 6'b001111,0,0));
        tab.push_back(mk(0,0,1,0,0,0, 6'b011111,0,1));
        tab.push_back(mk(0,0,1,0,0,0, 6'b011111,0,1));
        tab.push_back(mk(0,0,0,0,0,0, 6'b001111,0,1));
        tab.push_back(mk(0,0,0,0,0,0, 6'b000000,1,1));
        tab.push_back(mk(0,0,0,0,0,0, 6'b000000,0,0));
        // N=2, MEM stalls in the done cycle: done held until MEM frees
        tab.push_back(mk(0,0,0,0,1,2, 6'b001111,0,0));
        tab.push_back(mk(0,0,1,0,0,0, 6'b011111,1,1));
        tab.push_back(mk(0,0,0,0,0,0, 6'b000000,1,1));
        tab.push_back(mk(0,0,0,0,0,0, 6'b000000,0,0));
        foreach (tab[i]) begin
            apply_row(tab[i]);
            e = exp_q.pop_front();
            g = {stall, ex_multicycle_done, ex_multicycle_busy};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL mem_freeze row %0d: got stall=%b done=%b busy=%b want stall=%b done=%b busy=%b",
                         i, g[7:2], g[1], g[0], e[7:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_short_ops();
        row_t tab[$];
        logic [7:0] e, g;
        tab.push_back(mk(0,0,0,0,1,1, 6'b000000,1,0));
        tab.push_back(mk(0,0,0,0,0,0, 6'b000000,0,0));
        tab.push_back(mk(0,0,0,0,1,0, 6'b000000,1,0));
        tab.push_back(mk(0,0,0,0,0,0, 6'b000000,0,0));
        tab.push_back(mk(1,0,0,0,1,1, 6'b000011,1,0));
        tab.push_back(mk(0,0,0,0,0,0, 6'b000000,0,0));
        foreach (tab[i]) begin
            apply_row(tab[i]);
            e = exp_q.pop_front();
            g = {stall, ex_multicycle_done, ex_multicycle_busy};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL short_ops row %0d: got stall=%b done=%b busy=%b want stall=%b done=%b busy=%b",
                         i, g[7:2], g[1], g[0], e[7:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_flush();
        row_t tab[$];
        logic [7:0] e, g;
        // N=7: counter 6 then 5; flush with id request at counter 5
        tab.push_back(mk(0,0,0,0,1,7, 6'b001111,0,0));
        tab.push_back(mk(0,0,0,0,0,0, 6'b001111,0,1));
        tab.push_back(mk(0,1,0,1,0,0, 6'b000000,0,1));
        tab.push_back(mk(0,0,0,0,0,0, 6'b000000,0,0));
        tab.push_back(mk(0,0,0,0,0,0, 6'b000000,0,0));
        // flush together with start in IDLE: start ignored
        tab.push_back(mk(0,0,0,1,1,5, 6'b000000,0,0));
        tab.push_back(mk(0,0,0,0,0,0, 6'b000000,0,0));
        // flush in the done cycle suppresses done
        tab.push_back(mk(0,0,0,0,1,2, 6'b001111,0,0));
        tab.push_back(mk(0,0,0,1,0,0, 6'b000000,0,1));
        tab.push_back(mk(0,0,0,0,0,0, 6'b000000,0,0));
        foreach (tab[i]) begin
            apply_row(tab[i]);
            e = exp_q.pop_front();
            g = {stall, ex_multicycle_done, ex_multicycle_busy};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL flush row %0d: got stall=%b done=%b busy=%b want stall=%b done=%b busy=%b",
                         i, g[7:2], g[1], g[0], e[7:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_reset_abort();
        row_t tab[$];
        logic [7:0] e, g;
        tab.push_back(mk(0,0,0,0,1,6, 6'b001111,0,0));
        tab.push_back(mk(0,0,0,0,0,0, 6'b001111,0,1));
        foreach (tab[i]) begin
            apply_row(tab[i]);
            e = exp_q.pop_front();
            g = {stall, ex_multicycle_done, ex_multicycle_busy};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL reset_abort row %0d: got stall=%b done=%b busy=%b want stall=%b done=%b busy=%b",
                         i, g[7:2], g[1], g[0], e[7:2], e[1], e[0]);
            end
        end
        // Asynchronous reset between edges while BUSY
        @(negedge clock);
        #2;
        reset = 1'b1;
        exp_q.push_back(8'b000000_0_0);
        #1;
        e = exp_q.pop_front();
        g = {stall, ex_multicycle_done, ex_multicycle_busy};
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL reset_abort_async: got %b want %b", g, e);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply_row(mk(0,0,0,0,0,0, 6'b000000,0,0));
            e = exp_q.pop_front();
            g = {stall, ex_multicycle_done, ex_multicycle_busy};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL reset_abort_after %0d: got %b want %b", k, g, e);
            end
        end
    endtask

    task automatic test_stall_counter();
        logic [7:0] e, g;
        int exp_count;
        @(negedge clock);
        reset = 1'b1;
        #1;
        vectors++;
        if (stall_cycle_count !== 32'd0) begin
            miscompares++;
            $display("FAIL counter_cleared: got %0d want 0", stall_cycle_count);
        end
        @(negedge clock);
        reset = 1'b0;
        // 7 cycles with an IF stall request, the fourth also flushed
        for (int k = 0; k < 7; k++) begin
            if (k == 3)
                apply_row(mk(1,0,0,1,0,0, 6'b000000,0,0));
            else
                apply_row(mk(1,0,0,0,0,0, 6'b000011,0,0));
            e = exp_q.pop_front();
            g = {stall, ex_multicycle_done, ex_multicycle_busy};
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL counter_stim %0d: got %b want %b", k, g, e);
            end
        end
        apply_row(mk(0,0,0,0,0,0, 6'b000000,0,0));
        void'(exp_q.pop_front());
`ifdef STALL_COUNTER_EN
        exp_count = 6;
`else
        exp_count = 0;
`endif
        vectors++;
        if (stall_cycle_count !== 32'(exp_count)) begin
            miscompares++;
            $display("FAIL stall_cycle_count: got %0d want %0d", stall_cycle_count, exp_count);
        end
        // Idle cycles must not count
        apply_row(mk(0,0,0,0,0,0, 6'b000000,0,0));
        void'(exp_q.pop_front());
        apply_row(mk(0,0,0,0,0,0, 6'b000000,0,0));
        void'(exp_q.pop_front());
        vectors++;
        if (stall_cycle_count !== 32'(exp_count)) begin
            miscompares++;
            $display("FAIL stall_cycle_count_idle: got %0d want %0d", stall_cycle_count, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_requests();
        test_multicycle();
        test_mem_freeze();
        test_short_ops();
        test_flush();
        test_reset_abort();
        test_stall_counter();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central stall/bubble controller for the six-stage pipeline (PC, IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into the 6-bit stall vector consumed by the PC register and every inter-stage latch.
- Owns the multi-cycle EX sequencer (MADD/MSUB/DIV-style ops), which holds EX for a programmed number of cycles.
- Accepts a flush that aborts all stalls and the sequencer.

Parameters:
- COUNT_WIDTH, 6, width of the multi-cycle length input and internal down-counter.
- STALL_COUNT_WIDTH, 32, width of the optional stall-cycle counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- if_stall_request  input  1  instruction bus busy.
- id_stall_request  input  1  load-use hazard.
- mem_stall_request  input  1  data bus busy.
- flush  input  1  exception or redirect; overrides everything.
- ex_multicycle_start  input  1  single-cycle pulse; EX begins a multi-cycle op.
- ex_multicycle_cycles  input  COUNT_WIDTH  total EX occupancy N, sampled with start.
- stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = `STALL_ENABLE.
- ex_multicycle_done  output  1  EX result valid this cycle.
- ex_multicycle_busy  output  1  sequencer in BUSY.
- stall_cycle_count  output  STALL_COUNT_WIDTH  see Optional Feature.

Behaviour:
- stall, done and busy are combinational from the current state and inputs, because the latches sample stall in the same cycle.
- Registered state: sequencer state, counter, and the optional stall counter.
- Stall vector priority (deepest stage wins):
  - mem request -> 011111
  - ex_hold -> 001111
  - id request -> 000111
  - if request -> 000011
  - none -> 000000
- ex_hold comes from the sequencer (defined below). stall[5] is never asserted.
- A latch with stall[n]=1 and stall[n+1]=0 inserts a bubble. This is a property of the vector and needs no extra logic here.
- Sequencer states and transitions:
  - IDLE, start=1, N>=2: ex_hold=1 this cycle; next state BUSY; counter <= N-1.
  - IDLE, start=1, N in {0,1}: no hold; done=1 this cycle; remain IDLE.
  - BUSY, counter>1: ex_hold=1; counter decrements unless mem_stall_request=1, in which case it holds.
  - BUSY, counter==1: done=1; ex_hold=0; go to IDLE unless mem_stall_request=1, in which case remain BUSY with done held high.
  - Result: an N-cycle op holds EX for exactly N-1 cycles when MEM does not stall.
- start while BUSY: ignored; the counter is not reloaded.
- busy = (state==BUSY).
- flush=1:
  - stall=000000 and done=0 this cycle.
  - Next state IDLE, counter <= 0.
  - start in the same cycle is ignored.
  - Flush has priority over every request.
- Reset (asynchronous, active-high):
  - State IDLE, counter 0, stall_cycle_count 0.
  - Outputs therefore read stall=000000 (absent requests), done=0, busy=0.
  - Reset asserted mid-operation aborts immediately, with no done pulse.

Optional Feature:
- Macro STALL_COUNTER_EN.
- Defined: stall_cycle_count increments by 1 on every clock edge where stall[0]=1 and flush=0. It wraps modulo 2^STALL_COUNT_WIDTH and clears on reset.
- Undefined: no counter register; stall_cycle_count is tied to 0.

Decomposition:
- Shared defines header: `STALL_ENABLE/`STALL_DISABLE, `RESET_ENABLE, stage index constants (STAGE_PC..STAGE_WB = 0..5), and the sequencer state encodings.
- One natural sub-module: ex_multicycle_sequencer.
  - Contains the state, counter, done and busy logic.
  - Outputs ex_hold.
  - The top level does priority encoding and the optional counter.

Test Plan:
- Reset, then individual requests: if only -> 000011; id only -> 000111; mem only -> 011111; all three -> 011111.
- start with N=4, no other requests: stall=001111 for 3 cycles, then 000000 with done=1 on cycle 4; busy high cycles 2-4.
- start with N=3 and mem_stall_request high for 2 cycles mid-op: counter freezes; done is delayed 2 cycles; stall=011111 during the mem stall.
- start with N=1 and N=0: done=1 in the start cycle, stall stays 000000, busy never asserts.
- flush during BUSY (counter=5) together with id request: stall=000000 that cycle; next cycle busy=0; no done pulse. Reset asserted mid-op gives the same abort.
- With STALL_COUNTER_EN defined: 7 stalled cycles, 1 of them flushed -> stall_cycle_count=6. Without the macro: stall_cycle_count reads 0.
